jstk_axis_conditioner: RTL and testbench
========================================

// Module: jstk_axis_conditioner
// PURPOSE
// - Sits between the JSTK2 SPI interface and the Steering_X / Steering_Y PWM stages.
// - Takes raw 10-bit joystick samples per axis (0..1023) and produces 11-bit servo pulse widths in us.
// - Each axis is processed in three steps: 4-sample moving average, deadzone around centre, slew-rate limit.
// - Output is offset by +1000, giving 1000..2023 us, the range Steering_X / Steering_Y consume.
// PARAMETERS
// - CENTER    512  raw code treated as stick-centre
// - DEADZONE  24   |avg-CENTER| <= DEADZONE snaps to CENTER
// - MAX_STEP  16   max change of the conditioned value per accepted sample
// - SERVO_OFS 1000 pulse-width offset added at output (us)
// PORTS
// - clk          in   1   system clock (100 MHz)
// - rst          in   1   synchronous, active-high reset
// - sample_valid in   1   1-cycle strobe: x_raw/y_raw hold a new packet
// - x_raw        in   10  raw X position from SPI interface
// - y_raw        in   10  raw Y position from SPI interface
// - x_servo      out  11  conditioned X pulse width, us
// - y_servo      out  11  conditioned Y pulse width, us
// - servo_valid  out  1   1-cycle strobe: x_servo/y_servo just updated
// BEHAVIOUR
// - Reset:
//   - x_servo = y_servo = SERVO_OFS+CENTER (1512); servo_valid = 0.
//   - All 4 history slots := CENTER; running sums := 4*CENTER; slew state := CENTER.
// - Pipeline: 3 stages, fully pipelined; accepts sample_valid on every cycle, no backpressure.
//   - Sample_valid at cycle N -> servo_valid and new outputs at cycle N+3.
//   - S1 average: sum <= sum + raw - oldest; history shift; avg = sum[11:2] (truncate, 12-bit sum).
//   - S2 deadzone: target = (|avg-CENTER| <= DEADZONE) ? CENTER : avg. Signed 11-bit compare; no wrap.
//   - S3 slew: d = target - cur (signed 11b).
//     - d > MAX_STEP: cur += MAX_STEP.
//     - d < -MAX_STEP: cur -= MAX_STEP.
//     - Otherwise cur = target.
//     - Output = cur + SERVO_OFS (11b, max 2023, no overflow).
// - Slew state and averaging history update only on valid-qualified stages; idle cycles hold all state.
// - Outputs hold their value between servo_valid strobes (registered, glitch-free).
// - Raw 1023 for many samples -> average 1023 -> output 2023; raw 0 -> 1000. Clamp is unnecessary but asserted.
// - Back-to-back sample_valid: each sample processed independently; slew applies once per sample.
// - rst mid-pipeline: all in-flight valids dropped, no servo_valid for 3 cycles; state returns to reset values the cycle after rst.
// - rst and sample_valid in the same cycle: reset wins, sample discarded.
// - X and Y paths are identical and independent; they share only the valid pipeline.
// STRUCTURE
// - steering_pkg holds:
//   - RAW_W=10, SERVO_W=11, SUM_W=12.
//   - Default CENTER / SERVO_OFS / DEADZONE / MAX_STEP localparams.
//   - typedef raw_t, servo_t.
// - Sub-module axis_cond: one axis through all 3 stages; instantiated twice (X, Y).
// - Top keeps the shared valid shift register [2:0] feeding servo_valid.
// TESTING
// - Reset release, no samples -> x_servo=y_servo=1512, servo_valid=0 indefinitely.
// - Single strobe, x_raw=530 -> 3 cycles later servo_valid=1, x_servo=1512 (avg 516, in deadzone).
// - x_raw=1023 on 80 consecutive strobes -> x_servo rises by <=16 per strobe, settles 2023, never exceeds it.
// - Step x_raw 1023 -> 0, y_raw held 512 -> x_servo falls by <=16 per strobe to 1000; y_servo stays 1512.
// - Strobes every cycle for 10 cycles -> exactly 10 servo_valid pulses, each 3 cycles after its strobe.
// - rst asserted 1 cycle after a strobe -> no servo_valid follows; outputs 1512 the cycle after rst.

Source files
------------

// File: rtl/steering_pkg.sv
// Shared widths, default tuning constants and data types for the joystick-to-servo
// conditioning path.
package steering_pkg;

  localparam int unsigned RAW_W   = 10;
  localparam int unsigned SERVO_W = 11;
  localparam int unsigned SUM_W   = 12;

  localparam int unsigned CENTER_DEF    = 512;
  localparam int unsigned DEADZONE_DEF  = 24;
  localparam int unsigned MAX_STEP_DEF  = 16;
  localparam int unsigned SERVO_OFS_DEF = 1000;

  typedef logic [RAW_W-1:0]   raw_t;
  typedef logic [SERVO_W-1:0] servo_t;
  typedef logic [SUM_W-1:0]   sum_t;

endpackage

// File: rtl/axis_cond.sv
// One joystick axis: 4-sample moving average, deadzone snap to centre, slew-rate
// limit, then offset into servo pulse-width microseconds.
module axis_cond
  import steering_pkg::*;
#(
  parameter int unsigned CENTER    = CENTER_DEF,
  parameter int unsigned DEADZONE  = DEADZONE_DEF,
  parameter int unsigned MAX_STEP  = MAX_STEP_DEF,
  parameter int unsigned SERVO_OFS = SERVO_OFS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s1_en,
  input  logic               s2_en,
  input  logic               s3_en,
  input  logic [RAW_W-1:0]   raw,
  output logic [SERVO_W-1:0] servo
);

  localparam int unsigned DW = RAW_W + 1;

  localparam raw_t                 CEN_R     = RAW_W'(CENTER);
  localparam raw_t                 STEP_R    = RAW_W'(MAX_STEP);
  localparam logic signed [DW-1:0] CEN_S     = DW'(CENTER);
  localparam logic signed [DW-1:0] DZ_S      = DW'(DEADZONE);
  localparam logic signed [DW-1:0] STEP_S    = DW'(MAX_STEP);
  localparam servo_t               OFS_V     = SERVO_W'(SERVO_OFS);
  localparam servo_t               SERVO_MAX = SERVO_W'(SERVO_OFS + (1 << RAW_W) - 1);

  raw_t                 hist_q [4];
  sum_t                 sum_q, sum_d;
  raw_t                 avg;
  logic signed [DW-1:0] off, off_abs;
  raw_t                 target_d, target_q;
  logic signed [DW-1:0] d;
  raw_t                 cur_d, cur_q;
  servo_t               servo_d, servo_q;

  // Running sum drops the oldest slot so it never needs a full re-add.
  assign sum_d = sum_q + sum_t'(raw) - sum_t'(hist_q[3]);

  always_comb begin
    avg      = sum_q[SUM_W-1:2];
    off      = signed'({1'b0, avg}) - CEN_S;
    off_abs  = off[DW-1] ? -off : off;
    target_d = (off_abs <= DZ_S) ? CEN_R : avg;
  end

  always_comb begin
    d = signed'({1'b0, target_q}) - signed'({1'b0, cur_q});
    if (d > STEP_S)       cur_d = cur_q + STEP_R;
    else if (d < -STEP_S) cur_d = cur_q - STEP_R;
    else                  cur_d = target_q;
    servo_d = servo_t'(cur_d) + OFS_V;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 4; i++) hist_q[i] <= CEN_R;
      sum_q    <= SUM_W'(4 * CENTER);
      target_q <= CEN_R;
      cur_q    <= CEN_R;
      servo_q  <= SERVO_W'(SERVO_OFS + CENTER);
    end else begin
      if (s1_en) begin
        sum_q     <= sum_d;
        hist_q[0] <= raw;
        for (int unsigned i = 1; i < 4; i++) hist_q[i] <= hist_q[i-1];
      end
      if (s2_en) target_q <= target_d;
      if (s3_en) begin
        cur_q   <= cur_d;
        servo_q <= servo_d;
      end
    end
  end

  assign servo = servo_q;

  // The slewed value stays within raw range, so no output clamp is built.
  assert property (@(posedge clk) disable iff (rst)
    (servo_q >= OFS_V) && (servo_q <= SERVO_MAX));

endmodule

// File: rtl/jstk_axis_conditioner.sv
// Conditions raw JSTK2 X/Y samples into servo pulse widths; both axes share one
// 3-stage valid pipeline.
module jstk_axis_conditioner
  import steering_pkg::*;
#(
  parameter int unsigned CENTER    = CENTER_DEF,
  parameter int unsigned DEADZONE  = DEADZONE_DEF,
  parameter int unsigned MAX_STEP  = MAX_STEP_DEF,
  parameter int unsigned SERVO_OFS = SERVO_OFS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_valid,
  input  logic [RAW_W-1:0]   x_raw,
  input  logic [RAW_W-1:0]   y_raw,
  output logic [SERVO_W-1:0] x_servo,
  output logic [SERVO_W-1:0] y_servo,
  output logic               servo_valid
);

  logic [2:0] vld_q;

  always_ff @(posedge clk) begin
    if (rst) vld_q <= '0;
    else     vld_q <= {vld_q[1:0], sample_valid};
  end

  axis_cond #(
    .CENTER   (CENTER),
    .DEADZONE (DEADZONE),
    .MAX_STEP (MAX_STEP),
    .SERVO_OFS(SERVO_OFS)
  ) u_x (
    .clk  (clk),
    .rst  (rst),
    .s1_en(sample_valid),
    .s2_en(vld_q[0]),
    .s3_en(vld_q[1]),
    .raw  (x_raw),
    .servo(x_servo)
  );

  axis_cond #(
    .CENTER   (CENTER),
    .DEADZONE (DEADZONE),
    .MAX_STEP (MAX_STEP),
    .SERVO_OFS(SERVO_OFS)
  ) u_y (
    .clk  (clk),
    .rst  (rst),
    .s1_en(sample_valid),
    .s2_en(vld_q[0]),
    .s3_en(vld_q[1]),
    .raw  (y_raw),
    .servo(y_servo)
  );

  assign servo_valid = vld_q[2];

endmodule

// File: tb/tb_jstk_axis_conditioner.sv
// Bench for jstk_axis_conditioner: hand-computed vector table, directed corner
// sequences and randomized traffic against an integer reference model.
module tb_jstk_axis_conditioner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_valid = 1'b0;
  logic [9:0]  x_raw = 10'd512;
  logic [9:0]  y_raw = 10'd512;
  logic [10:0] x_servo, y_servo;
  logic        servo_valid;

  jstk_axis_conditioner dut (
    .clk         (clk),
    .rst         (rst),
    .sample_valid(sample_valid),
    .x_raw       (x_raw),
    .y_raw       (y_raw),
    .x_servo     (x_servo),
    .y_servo     (y_servo),
    .servo_valid (servo_valid)
  );

  always #5 clk = ~clk;

  int nerr = 0;
  int nchk = 0;
  int cyc  = 0;
  int npulse = 0;

  // Reference model state: raw history per axis (newest first) and slewed value.
  int mh [2][4];
  int mcur [2];
  typedef struct { int due; int x; int y; } exp_t;
  exp_t q[$];
  int hold_x = 1512, hold_y = 1512;

  typedef struct { int x; int y; int ex; int ey; } vec_t;
  vec_t tbl [5];

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    for (int a = 0; a < 2; a++) begin
      for (int i = 0; i < 4; i++) mh[a][i] = 512;
      mcur[a] = 512;
    end
    q.delete();
    hold_x = 1512;
    hold_y = 1512;
  endfunction

  function automatic int axis_model(input int a, input int raw);
    int avg, tgt;
    for (int i = 3; i > 0; i--) mh[a][i] = mh[a][i-1];
    mh[a][0] = raw;
    avg = (mh[a][0] + mh[a][1] + mh[a][2] + mh[a][3]) / 4;
    tgt = ((avg - 512 <= 24) && (512 - avg <= 24)) ? 512 : avg;
    if (tgt - mcur[a] > 16)       mcur[a] = mcur[a] + 16;
    else if (tgt - mcur[a] < -16) mcur[a] = mcur[a] - 16;
    else                          mcur[a] = tgt;
    return mcur[a] + 1000;
  endfunction

  task automatic check_outputs();
    int ev;
    int px, py;
    px = hold_x;
    py = hold_y;
    ev = (q.size() > 0 && q[0].due == cyc) ? 1 : 0;
    if (ev == 1) begin
      hold_x = q[0].x;
      hold_y = q[0].y;
      void'(q.pop_front());
    end
    chk("servo_valid", int'(servo_valid), ev);
    chk("x_servo", int'(x_servo), hold_x);
    chk("y_servo", int'(y_servo), hold_y);
    if (servo_valid) begin
      npulse++;
      chk("x_slew_ok", (int'(x_servo) - px <= 16 && px - int'(x_servo) <= 16) ? 1 : 0, 1);
      chk("x_range_ok", (int'(x_servo) >= 1000 && int'(x_servo) <= 2023) ? 1 : 0, 1);
    end
  endtask

  // Drive one cycle, advance the model on the sampling edge, check at the negedge.
  task automatic step(input logic r, input logic v, input int x, input int y);
    exp_t e;
    rst = r;
    sample_valid = v;
    x_raw = 10'(x);
    y_raw = 10'(y);
    @(posedge clk);
    cyc++;
    if (r) model_reset();
    else if (v) begin
      e.due = cyc + 2;
      e.x = axis_model(0, x);
      e.y = axis_model(1, y);
      q.push_back(e);
    end
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    int rx, ry;
    tbl[0] = '{x: 530,  y: 512, ex: 1512, ey: 1512};
    tbl[1] = '{x: 1023, y: 0,   ex: 1528, ey: 1496};
    tbl[2] = '{x: 1023, y: 0,   ex: 1544, ey: 1480};
    tbl[3] = '{x: 600,  y: 500, ex: 1560, ey: 1464};
    tbl[4] = '{x: 512,  y: 512, ex: 1576, ey: 1448};

    model_reset();
    @(negedge clk);
    step(1, 0, 512, 512);
    step(1, 0, 512, 512);
    chk("reset_x", int'(x_servo), 1512);
    chk("reset_y", int'(y_servo), 1512);
    chk("reset_valid", int'(servo_valid), 0);

    npulse = 0;
    for (int i = 0; i < 20; i++) step(0, 0, 0, 1023);
    chk("idle_pulses", npulse, 0);

    for (int i = 0; i < 5; i++) begin
      step(0, 1, tbl[i].x, tbl[i].y);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("tbl_valid", int'(servo_valid), 1);
      chk("tbl_x", int'(x_servo), tbl[i].ex);
      chk("tbl_y", int'(y_servo), tbl[i].ey);
    end

    for (int i = 0; i < 80; i++) step(0, 1, 1023, 512);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    chk("sat_high_x", int'(x_servo), 2023);
    chk("sat_high_y", int'(y_servo), 1512);

    for (int i = 0; i < 80; i++) step(0, 1, 0, 512);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    chk("sat_low_x", int'(x_servo), 1000);
    chk("sat_low_y", int'(y_servo), 1512);

    npulse = 0;
    for (int i = 0; i < 10; i++) step(0, 1, 100 * i, 1023 - 100 * i);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    chk("b2b_pulses", npulse, 10);

    step(0, 1, 900, 100);
    npulse = 0;
    step(1, 0, 0, 0);
    chk("rst_mid_x", int'(x_servo), 1512);
    chk("rst_mid_y", int'(y_servo), 1512);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    chk("rst_mid_pulses", npulse, 0);

    npulse = 0;
    step(1, 1, 1023, 1023);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    chk("rst_wins_pulses", npulse, 0);
    chk("rst_wins_x", int'(x_servo), 1512);

    for (int i = 0; i < 1500; i++) begin
      rx = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 1023 : 0)
                                       : int'($urandom_range(0, 1023));
      ry = ($urandom_range(0, 3) == 0) ? int'($urandom_range(490, 535))
                                       : int'($urandom_range(0, 1023));
      step(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0, rx, ry);
    end
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
